p_serializer_27_bits: RTL and testbench
=======================================

# p_serializer_27_bits

Parallel-in, serial-out transmitter for 27-bit words, MSB first, one bit per clock. It is the sending end of the 27-bit serial link. A downstream 27-stage serial-in shift register, clocked on the same clock, holds the complete word in its outputs on the cycle after the last bit is sent. It carries the 27-bit extended significand (mantissa plus guard/round/sticky) between floating-point stages. It accepts a new word through a valid/ready handshake and supports back-to-back frames with no idle bit between them.

## Interface
- WIDTH, 27, word length in bits. Counter width is ceil(log2(WIDTH)), which is 5 at the default.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  a word is present on load_data.
- load_data  input  WIDTH  word to transmit. Sampled only on an accepting edge.
- load_ready  output  1  the block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_last  output  1  ser_out carries bit 0, the final bit of the frame.
- frame_done  output  1  one-cycle pulse on the cycle after ser_last. The receiver holds the full word on this cycle.

## Operation
- Internal state:
  - WIDTH-bit shift register shreg.
  - Bit counter cnt, counting 0..WIDTH-1.
  - Two-state FSM: IDLE, SHIFT.
- Accept is defined as load_valid & load_ready on a rising edge.
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0, ser_last=0.
  - On accept: shreg<=load_data, cnt<=0, go to SHIFT.
- SHIFT:
  - ser_out=shreg[WIDTH-1], ser_valid=1, ser_last=(cnt==WIDTH-1).
  - Each edge while cnt<WIDTH-1: shreg<=shreg<<1 (zero fill), cnt<=cnt+1.
  - load_ready=0 while cnt<WIDTH-1, and load_ready=1 when cnt==WIDTH-1.
- End of frame (cnt==WIDTH-1):
  - With accept: reload shreg<=load_data, cnt<=0, stay in SHIFT. The next frame's bit WIDTH-1 follows bit 0 directly, with no gap.
  - Without accept: go to IDLE.
- frame_done is registered: frame_done <= (state==SHIFT) & (cnt==WIDTH-1). It pulses on every completed frame, including back-to-back ones.
- Bit order: the first bit sent is load_data[WIDTH-1] and the last is load_data[0]. A receiver that shifts into its bit 0 ends with its out[k]==load_data[k].
- load_data is captured only on accept. Changes at any other time have no effect.
- If load_valid is held high continuously, frames stream without gaps.

## Timing
- Reset (rst=1 on an edge) takes priority over every other event. After the edge:
  - state=IDLE, shreg=0, cnt=0.
  - ser_out=0, ser_valid=0, ser_last=0, frame_done=0.
  - load_ready=1.
- Reset during SHIFT aborts the frame. No frame_done is issued for the aborted frame, and no partial word is reported.
- An accept in the same cycle as rst is ignored.
- Latency:
  - Accept at edge E0 puts bit WIDTH-1 on ser_out in the cycle after E0.
  - Bit 0 appears WIDTH-1 cycles later, with ser_last=1.
  - frame_done=1 in the following cycle.
  - Accept-to-frame_done is WIDTH+1 cycles.
- Throughput is 1 word per WIDTH cycles when loads are back-to-back.
- Outputs are glitch-free functions of registered state only. There is no combinational path from load_valid to any output, including load_ready.
- cnt never exceeds WIDTH-1 and has no wrap-around beyond the defined reload.

## Test plan
- Reset then idle: assert rst for 2 cycles, then release with load_valid=0 for 10 cycles. Required: ser_valid=0, ser_out=0, frame_done=0 and load_ready=1 throughout.
- Single frame: load 27'h5A5A5A5 for one cycle. Required:
  - ser_valid is high for exactly 27 cycles, with bits in order 1,0,1,1,0,1,0,0,...,1 (MSB first).
  - ser_last is high on the 27th bit, and frame_done pulses once on the next cycle.
  - A reference 27-bit SIPO holds 27'h5A5A5A5 on that cycle.
- Back-to-back: hold load_valid high with 27'h7FFFFFF, then 27'h0000001. Required:
  - load_ready pulses only on the ser_last cycles.
  - 54 contiguous ser_valid cycles (27 ones, then 26 zeros and a final one).
  - frame_done pulses twice, 27 cycles apart.
- Data stability: after accepting 27'h4000001, toggle load_data randomly every cycle with load_valid=0. Required: the transmitted stream is 1, 25 zeros, 1, and load_ready stays 0 until ser_last.
- Reset mid-frame: accept 27'h2AAAAAA, then assert rst at bit 10. Required: all outputs return to 0 and load_ready to 1 the next cycle, with no frame_done pulse. A new load of 27'h1555555 then transmits correctly from its MSB.
- Reset wins over accept: assert rst and load_valid with 27'h7FFFFFF in the same cycle. Required: ser_valid=0 for the following 5 cycles.

Source files
------------

// File: rtl/p_serializer_27_bits.sv
// Parallel-in, serial-out transmitter, MSB first, one bit per clock, back-to-back frames.
// Latency: first bit the cycle after accept, frame_done WIDTH+1 cycles after accept.
// Backpressure: load_ready only while idle or on the last bit; load_data is held upstream until accepted.
module p_serializer_27_bits #(
  parameter int WIDTH = 27,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             frame_done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;

  // Every output is decoded from registered state only, so load_ready has no path from load_valid.
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;

    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        ser_out   = shreg_q[WIDTH-1];
        ser_valid = 1'b1;
        ser_last  = last_bit;
        if (last_bit) begin
          load_ready = 1'b1;
          cnt_d      = '0;
          if (load_valid) begin
            shreg_d = load_data;
          end else begin
            shreg_d = '0;
            state_d = IDLE;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      frame_done <= last_bit;
    end
  end

endmodule

// File: tb/tb_p_serializer_27_bits.sv
// Directed bench for p_serializer_27_bits with a reference 27-stage SIPO on the serial side.
module tb_p_serializer_27_bits;

  localparam int WIDTH = 27;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             frame_done;

  logic [WIDTH-1:0] sipo;
  int               n_cmp;
  int               n_err;

  p_serializer_27_bits #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) sipo <= '0;
    else if (ser_valid) sipo <= {sipo[WIDTH-2:0], ser_out};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ser_valid, ser_out, ser_last, load_ready, frame_done}
  function automatic logic [31:0] status();
    return {27'd0, ser_valid, ser_out, ser_last, load_ready, frame_done};
  endfunction

  // Called on the cycle carrying bit WIDTH-1; returns on the cycle after bit 0.
  task automatic expect_frame(input string tag, input logic [WIDTH-1:0] w, input bit done_first,
                              input bit next_vld, input logic [WIDTH-1:0] next_dat, input bit rnd);
    logic [4:0] e;
    load_valid = next_vld;
    load_data  = next_dat;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e = {1'b1, w[i], (i == 0), (i == 0), (i == WIDTH - 1) ? done_first : 1'b0};
      check($sformatf("%s_bit%0d", tag, i), status(), {27'd0, e});
      tick();
      if (rnd) load_data = WIDTH'($urandom);
    end
    check({tag, "_done"}, {31'd0, frame_done}, 32'd1);
    check({tag, "_sipo"}, {5'd0, sipo}, {5'd0, w});
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

    // Reset, then idle
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("idle%0d", i), status(), 32'b00010);
      tick();
    end

    // Single frame
    load_valid = 1'b1;
    load_data  = 27'h5A5A5A5;
    tick();
    expect_frame("single", 27'h5A5A5A5, 1'b0, 1'b0, '0, 1'b0);
    check("single_idle", status(), 32'b00011);
    tick();
    check("single_after", status(), 32'b00010);

    // Back-to-back frames with load_valid held high
    load_valid = 1'b1;
    load_data  = 27'h7FFFFFF;
    tick();
    expect_frame("b2b_a", 27'h7FFFFFF, 1'b0, 1'b1, 27'h0000001, 1'b0);
    expect_frame("b2b_b", 27'h0000001, 1'b1, 1'b0, '0, 1'b0);
    check("b2b_idle", status(), 32'b00011);
    tick();

    // load_data churns while not ready
    load_valid = 1'b1;
    load_data  = 27'h4000001;
    tick();
    expect_frame("stable", 27'h4000001, 1'b0, 1'b0, '0, 1'b1);
    load_data = '0;
    tick();

    // Reset in the middle of a frame
    load_valid = 1'b1;
    load_data  = 27'h2AAAAAA;
    tick();
    load_valid = 1'b0;
    for (int i = WIDTH - 1; i > WIDTH - 11; i--) begin
      check($sformatf("abort_bit%0d", i), {31'd0, ser_out}, {31'd0, load_data[i]});
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rst", status(), 32'b00010);
    tick();
    check("abort_nodone", status(), 32'b00010);
    load_valid = 1'b1;
    load_data  = 27'h1555555;
    tick();
    expect_frame("post_rst", 27'h1555555, 1'b0, 1'b0, '0, 1'b0);
    tick();

    // Reset beats a simultaneous accept
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 27'h7FFFFFF;
    tick();
    rst        = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_win%0d", i), status(), 32'b00010);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
